// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between the CPU data port (m0) and the
// boot/stream loader (m1): CPU-weighted priority with bounded loader starvation.
module ram_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 100_000,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [WIDTH-1:0] m0_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [WIDTH-1:0] m0_rdata,
    output logic             m0_err,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [WIDTH-1:0] m1_addr,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [WIDTH-1:0] m1_rdata,
    output logic             m1_err,
    output logic             ram_enw,
    output logic [WIDTH-1:0] ram_address,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata
);
    localparam logic [WIDTH-1:0] LIMIT     = WIDTH'(DEPTH);
    localparam logic [3:0]       BURST_MAX = 4'(BURST);

    logic [3:0]       cnt;
    logic [3:0]       cnt_next;
    logic             any_gnt;
    logic             sel_owner;
    logic             sel_we;
    logic             sel_oor;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic             rd_valid;
    logic             rd_owner;
    logic             rd_oor;
    logic             wr_err;
    logic             wr_owner;

    // cnt only grows while both masters contend; every other case clears it.
    always_comb begin
        m0_gnt   = 1'b0;
        m1_gnt   = 1'b0;
        cnt_next = '0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                if (cnt < BURST_MAX) begin
                    m0_gnt   = 1'b1;
                    cnt_next = cnt + 4'd1;
                end else begin
                    m1_gnt = 1'b1;
                end
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        any_gnt   = m0_gnt | m1_gnt;
        sel_owner = m1_gnt;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (m0_gnt) begin
            sel_we    = m0_we;
            sel_addr  = m0_addr;
            sel_wdata = m0_wdata;
        end else if (m1_gnt) begin
            sel_we    = m1_we;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
    end

    assign sel_oor     = sel_addr >= LIMIT;
    assign ram_enw     = sel_we && !sel_oor;
    assign ram_address = sel_addr;
    assign ram_wdata   = sel_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rd_valid <= 1'b0;
            rd_owner <= 1'b0;
            rd_oor   <= 1'b0;
            wr_err   <= 1'b0;
            wr_owner <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            rd_valid <= any_gnt && !sel_we;
            rd_owner <= sel_owner;
            rd_oor   <= sel_oor;
            wr_err   <= any_gnt && sel_we && sel_oor;
            wr_owner <= sel_owner;
        end
    end

    // Returns are masked while rst is high so a read granted just before reset never surfaces.
    assign m0_rvalid = rd_valid && !rd_owner && !rst;
    assign m1_rvalid = rd_valid && rd_owner && !rst;
    assign m0_rdata  = (m0_rvalid && !rd_oor) ? ram_rdata : '0;
    assign m1_rdata  = (m1_rvalid && !rd_oor) ? ram_rdata : '0;
    assign m0_err    = (m0_rvalid && rd_oor) || (wr_err && !wr_owner && !rst);
    assign m1_err    = (m1_rvalid && rd_oor) || (wr_err && wr_owner && !rst);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table followed by random traffic,
// both checked against a transaction-level model of the arbiter and RAM.
module tb_ram_arbiter;
    localparam int WIDTH = 32;
    localparam int DEPTH = 100_000;
    localparam int BURST = 4;
    localparam int MEM_WORDS = 131072;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, ram_enw;
    logic [31:0] m0_rdata, m1_rdata, ram_address, ram_wdata;
    logic [31:0] ram_rdata = '0;

    logic [31:0] ram_mem [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        bit          rst;
        bit          r0;
        bit          w0;
        logic [31:0] a0;
        logic [31:0] d0;
        bit          r1;
        bit          w1;
        logic [31:0] a1;
        logic [31:0] d1;
    } stim_t;

    typedef struct {
        stim_t       s;
        bit          chk;
        bit          g0;
        bit          g1;
        bit          enw;
        bit          v0;
        logic [31:0] q0;
        bit          e0;
        bit          v1;
        logic [31:0] q1;
        bit          e1;
    } vec_t;

    vec_t vectors[$];

    // Reference model state: length of the current contested CPU-win streak,
    // and what each master should see on its return path this cycle.
    int          streak = 0;
    int          next_streak;
    int          winner;
    bit          win_we;
    logic [31:0] win_addr;
    logic [31:0] win_data;
    bit          ret_v [2];
    logic [31:0] ret_q [2];
    bit          ret_e [2];

    ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BURST(BURST)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_enw(ram_enw), .ram_address(ram_address), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_enw && ram_address[31:17] == 15'd0)
            ram_mem[ram_address[16:0]] <= ram_wdata;
        ram_rdata <= (ram_address[31:17] == 15'd0) ? ram_mem[ram_address[16:0]] : 32'h0;
    end

    function automatic void checkOutput(input string name, input logic [31:0] act,
                                        input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endfunction

    function automatic stim_t mk(input bit rs, input bit r0, input bit w0, input logic [31:0] a0,
                                 input logic [31:0] d0, input bit r1, input bit w1,
                                 input logic [31:0] a1, input logic [31:0] d1);
        stim_t s;
        s.rst = rs; s.r0 = r0; s.w0 = w0; s.a0 = a0; s.d0 = d0;
        s.r1 = r1; s.w1 = w1; s.a1 = a1; s.d1 = d1;
        return s;
    endfunction

    function automatic void row(input stim_t s, input bit g0, input bit g1, input bit enw,
                                input bit v0, input logic [31:0] q0, input bit e0,
                                input bit v1, input logic [31:0] q1, input bit e1);
        vec_t v;
        v.s = s; v.chk = 1'b1; v.g0 = g0; v.g1 = g1; v.enw = enw;
        v.v0 = v0; v.q0 = q0; v.e0 = e0; v.v1 = v1; v.q1 = q1; v.e1 = e1;
        vectors.push_back(v);
    endfunction

    function automatic logic [31:0] pickAddr();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 15));
            1: return 32'(DEPTH - 2 + $urandom_range(0, 3));
            2: return $urandom;
            default: return 32'($urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    function automatic stim_t randStim();
        return mk($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  pickAddr(), $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  pickAddr(), $urandom);
    endfunction

    task automatic applyStimulus(input stim_t s);
        rst = s.rst;
        m0_req = s.r0; m0_we = s.w0; m0_addr = s.a0; m0_wdata = s.d0;
        m1_req = s.r1; m1_we = s.w1; m1_addr = s.a1; m1_wdata = s.d1;
    endtask

    // Decide the winner from the priority rules and compare every output.
    task automatic checkAgainstModel();
        bit rv [2];
        logic [31:0] rq [2];
        bit re [2];
        winner = -1;
        next_streak = 0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                if (streak < BURST) begin
                    winner = 0;
                    next_streak = streak + 1;
                end else begin
                    winner = 1;
                end
            end else if (m0_req) winner = 0;
            else if (m1_req) winner = 1;
        end
        win_we   = (winner == 0) ? m0_we : (winner == 1) ? m1_we : 1'b0;
        win_addr = (winner == 0) ? m0_addr : (winner == 1) ? m1_addr : 32'h0;
        win_data = (winner == 0) ? m0_wdata : (winner == 1) ? m1_wdata : 32'h0;
        for (int m = 0; m < 2; m++) begin
            rv[m] = rst ? 1'b0 : ret_v[m];
            rq[m] = rst ? 32'h0 : ret_q[m];
            re[m] = rst ? 1'b0 : ret_e[m];
        end
        checkOutput("model m0_gnt", m0_gnt, 32'(winner == 0));
        checkOutput("model m1_gnt", m1_gnt, 32'(winner == 1));
        checkOutput("model ram_enw", ram_enw, 32'(win_we && win_addr < DEPTH));
        checkOutput("model ram_address", ram_address, win_addr);
        checkOutput("model ram_wdata", ram_wdata, win_data);
        checkOutput("model m0_rvalid", m0_rvalid, 32'(rv[0]));
        checkOutput("model m0_rdata", m0_rdata, rq[0]);
        checkOutput("model m0_err", m0_err, 32'(re[0]));
        checkOutput("model m1_rvalid", m1_rvalid, 32'(rv[1]));
        checkOutput("model m1_rdata", m1_rdata, rq[1]);
        checkOutput("model m1_err", m1_err, 32'(re[1]));
    endtask

    task automatic commitModel();
        bit oor;
        oor = win_addr >= DEPTH;
        for (int m = 0; m < 2; m++) begin
            ret_v[m] = 1'b0;
            ret_q[m] = 32'h0;
            ret_e[m] = 1'b0;
        end
        if (winner >= 0) begin
            ret_e[winner] = oor;
            if (win_we) begin
                if (!oor) ref_mem[win_addr[16:0]] = win_data;
            end else begin
                ret_v[winner] = 1'b1;
                ret_q[winner] = oor ? 32'h0 : ref_mem[win_addr[16:0]];
            end
        end
        streak = rst ? 0 : next_streak;
    endtask

    task automatic runCycle(input vec_t v);
        @(negedge clk);
        applyStimulus(v.s);
        #1;
        checkAgainstModel();
        if (v.chk) begin
            checkOutput("vec m0_gnt", m0_gnt, 32'(v.g0));
            checkOutput("vec m1_gnt", m1_gnt, 32'(v.g1));
            checkOutput("vec ram_enw", ram_enw, 32'(v.enw));
            checkOutput("vec m0_rvalid", m0_rvalid, 32'(v.v0));
            checkOutput("vec m0_rdata", m0_rdata, v.q0);
            checkOutput("vec m0_err", m0_err, 32'(v.e0));
            checkOutput("vec m1_rvalid", m1_rvalid, 32'(v.v1));
            checkOutput("vec m1_rdata", m1_rdata, v.q1);
            checkOutput("vec m1_err", m1_err, 32'(v.e1));
        end
        @(posedge clk);
        commitModel();
    endtask

    initial begin
        stim_t both, both_rst, idle;
        vec_t rv;
        logic [31:0] beef, a5, w1234;
        beef = 32'hDEADBEEF;
        a5 = 32'hA5A50007;
        w1234 = 32'h12345678;

        for (int i = 0; i < MEM_WORDS; i++) begin
            ram_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        ram_mem[5] = beef; ref_mem[5] = beef;
        ram_mem[7] = a5;   ref_mem[7] = a5;

        both     = mk(0, 1, 0, 7, 0, 1, 0, 5, 0);
        both_rst = mk(1, 1, 0, 7, 0, 1, 0, 5, 0);
        idle     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset with both masters requesting.
        for (int i = 0; i < 3; i++) row(both_rst, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Contention: four CPU grants, then one loader grant, twice.
        row(both, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        row(both, 1, 0, 0, 1, a5, 0, 0, 0, 0);
        row(both, 1, 0, 0, 1, a5, 0, 0, 0, 0);
        row(both, 1, 0, 0, 1, a5, 0, 0, 0, 0);
        row(both, 0, 1, 0, 1, a5, 0, 0, 0, 0);
        row(both, 1, 0, 0, 0, 0, 0, 1, beef, 0);
        row(both, 1, 0, 0, 1, a5, 0, 0, 0, 0);
        row(both, 1, 0, 0, 1, a5, 0, 0, 0, 0);
        row(both, 1, 0, 0, 1, a5, 0, 0, 0, 0);
        row(both, 0, 1, 0, 1, a5, 0, 0, 0, 0);
        // Loader reads alone.
        row(mk(0, 0, 0, 0, 0, 1, 0, 5, 0), 0, 1, 0, 0, 0, 0, 1, beef, 0);
        row(idle, 0, 0, 0, 0, 0, 0, 1, beef, 0);
        // Write then read the last valid word.
        row(mk(0, 1, 1, DEPTH - 1, w1234, 0, 0, 0, 0), 1, 0, 1, 0, 0, 0, 0, 0, 0);
        row(mk(0, 1, 0, DEPTH - 1, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0, 0, 0);
        row(idle, 0, 0, 0, 1, w1234, 0, 0, 0, 0);
        // First out-of-range address: write blocked, read flagged.
        row(mk(0, 0, 0, 0, 0, 1, 1, DEPTH, 32'hFFFFFFFF), 0, 1, 0, 0, 0, 0, 0, 0, 0);
        row(mk(0, 0, 0, 0, 0, 1, 0, DEPTH, 0), 0, 1, 0, 0, 0, 0, 0, 0, 1);
        row(idle, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        row(mk(0, 0, 0, 0, 0, 1, 0, DEPTH - 1, 0), 0, 1, 0, 0, 0, 0, 0, 0, 0);
        row(idle, 0, 0, 0, 0, 0, 0, 1, w1234, 0);
        // Reset right after a contested read: read dropped, streak restarts.
        row(both, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        row(both_rst, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        row(both, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        row(both, 1, 0, 0, 1, a5, 0, 0, 0, 0);
        row(both, 1, 0, 0, 1, a5, 0, 0, 0, 0);
        row(both, 1, 0, 0, 1, a5, 0, 0, 0, 0);
        row(both, 0, 1, 0, 1, a5, 0, 0, 0, 0);
        row(idle, 0, 0, 0, 0, 0, 0, 1, beef, 0);

        foreach (vectors[i]) runCycle(vectors[i]);

        rv.chk = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            rv.s = randStim();
            runCycle(rv);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
